// File: rtl/multi_fifo_arb_pkg.sv
// Shared types and helpers for the multi-lane FIFO push arbiter.
//   arb_state_e : arbiter mode (ARB = round-robin scan, LOCK = starvation lock)
//   popcount    : number of set bits in a vector of up to 32 bits
package multi_fifo_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/multi_fifo_lane_pack.sv
// Combinational round-robin scan and lane packer.
// Requesters are visited from rr_ptr upward (mod REQ_NUM). An eligible
// requester is granted only if all of its entries fit in the remaining free
// lanes; otherwise it is skipped and the scan continues (greedy).
// Ports:
//   elig      : requesters allowed to win this cycle (valid, masked by lock)
//   req_num   : entries requested per requester
//   req_data  : per-requester entries, index 0 first
//   free      : free FIFO slots this cycle
//   rr_ptr    : scan start index
//   grant     : one bit per granted requester
//   push      : lanes used, packed from lane 0
//   datain    : lane data, unused lanes 0
//   any_grant : at least one grant this cycle
//   last_idx  : index of the last requester granted in scan order
module multi_fifo_lane_pack
  import multi_fifo_arb_pkg::*;
#(
  parameter type T          = logic [7:0],
  parameter int  M          = 4,
  parameter int  REQ_NUM    = 4,
  localparam int CNT_W      = $clog2(M + 1),
  localparam int RR_W       = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0]            elig,
  input  logic [REQ_NUM-1:0][CNT_W-1:0] req_num,
  input  T     [REQ_NUM-1:0][M-1:0]     req_data,
  input  logic [CNT_W-1:0]              free,
  input  logic [RR_W-1:0]               rr_ptr,
  output logic [REQ_NUM-1:0]            grant,
  output logic [M-1:0]                  push,
  output T     [M-1:0]                  datain,
  output logic                          any_grant,
  output logic [RR_W-1:0]               last_idx
);

  always_comb begin
    int used;
    int idx;
    int n;
    grant     = '0;
    push      = '0;
    datain    = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr;
    used      = 0;
    idx       = 0;
    n         = 0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(rr_ptr) + i) % REQ_NUM;
      n   = int'(req_num[idx]);
      // free != 0 keeps an illegal zero-length request from winning a full FIFO
      if (elig[idx] && (free != '0) && (used + n <= int'(free))) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
        last_idx   = RR_W'(idx);
        for (int k = 0; k < M; k++) begin
          if (k < n) begin
            push[used + k]   = 1'b1;
            datain[used + k] = req_data[idx][k];
          end
        end
        used += n;
      end
    end
  end

endmodule

// File: rtl/multi_fifo_push_arb.sv
// Multi-requester arbiter feeding an M-lane push port of a FIFO.
// Each cycle, whole requests are packed into the free FIFO slots in
// round-robin order; ready, push and lane data are combinational.
// Optional starvation lock: define MULTI_FIFO_PUSH_ARB_STARVE_EN to add
// per-requester starve counters and a LOCK state that reserves the FIFO for a
// requester blocked for STARVE_LIMIT cycles. Without it lock_active is 0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   clear            : synchronous clear of rr_ptr, state and counters
//   req_valid        : request pending per requester (held until ready)
//   req_num          : entries requested per requester (1..M)
//   req_data         : entries per requester, index 0 first
//   req_ready        : grant; transfer on valid & ready
//   fifo_almost_full : bit i set means free slots <= i
//   fifo_push        : push lanes, packed from lane 0
//   fifo_datain      : lane data, unused lanes 0
//   lock_active      : starvation lock in force
//   rr_ptr           : current round-robin start index
module multi_fifo_push_arb
  import multi_fifo_arb_pkg::*;
#(
  parameter type T            = logic [7:0],
  parameter int  M            = 4,
  parameter int  REQ_NUM      = 4,
  parameter int  STARVE_LIMIT = 8,
  localparam int CNT_W        = $clog2(M + 1),
  localparam int RR_W         = $clog2(REQ_NUM)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM-1:0][CNT_W-1:0] req_num,
  input  T     [REQ_NUM-1:0][M-1:0]     req_data,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic [M-1:0]                  fifo_almost_full,
  output logic [M-1:0]                  fifo_push,
  output T     [M-1:0]                  fifo_datain,
  output logic                          lock_active,
  output logic [RR_W-1:0]               rr_ptr
);

  if (M < 1 || M > 32 || REQ_NUM < 2 || STARVE_LIMIT < 1) begin : g_bad_cfg
    $error("multi_fifo_push_arb: unsupported parameter set");
  end

  logic [CNT_W-1:0]   free;
  logic [REQ_NUM-1:0] elig;
  logic [REQ_NUM-1:0] grant;
  logic               any_grant;
  logic [RR_W-1:0]    last_idx;
  logic [RR_W-1:0]    rr_next;

  // almost_full is a thermometer code, so its popcount is the occupied depth
  assign free = CNT_W'(M - int'(popcount(32'(fifo_almost_full))));

  multi_fifo_lane_pack #(
    .T       (T),
    .M       (M),
    .REQ_NUM (REQ_NUM)
  ) u_lane_pack (
    .elig      (elig),
    .req_num   (req_num),
    .req_data  (req_data),
    .free      (free),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .push      (fifo_push),
    .datain    (fifo_datain),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  assign req_ready = grant;
  assign rr_next   = any_grant ? RR_W'((int'(last_idx) + 1) % REQ_NUM) : rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (clear) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

`ifdef MULTI_FIFO_PUSH_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e                      state, state_next;
  logic [RR_W-1:0]                 lock_id, lock_id_next;
  logic [REQ_NUM-1:0][SC_W-1:0]    starve_cnt, starve_cnt_next;

  always_comb begin
    for (int r = 0; r < REQ_NUM; r++) begin
      if (req_valid[r] && !grant[r]) begin
        starve_cnt_next[r] = (starve_cnt[r] == SC_W'(STARVE_LIMIT)) ?
                             starve_cnt[r] : starve_cnt[r] + 1'b1;
      end else begin
        starve_cnt_next[r] = '0;
      end
    end
  end

  // Lock is decided on the counter value being loaded, so a requester blocked
  // for STARVE_LIMIT cycles is locked in on the very next cycle.
  always_comb begin
    state_next   = state;
    lock_id_next = lock_id;
    case (state)
      ARB: begin
        for (int r = REQ_NUM - 1; r >= 0; r--) begin
          if (starve_cnt_next[r] == SC_W'(STARVE_LIMIT)) begin
            state_next   = LOCK;
            lock_id_next = RR_W'(r);
          end
        end
      end
      LOCK: begin
        if (grant[lock_id] || !req_valid[lock_id]) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      lock_id    <= '0;
      starve_cnt <= '0;
    end else if (clear) begin
      state      <= ARB;
      lock_id    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      lock_id    <= lock_id_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  assign elig        = (state == LOCK) ?
                       (req_valid & ({{(REQ_NUM-1){1'b0}}, 1'b1} << lock_id)) : req_valid;
  assign lock_active = (state == LOCK);
`else
  assign elig        = req_valid;
  assign lock_active = 1'b0;
`endif

`ifdef ASSERT_ON
  for (genvar r = 0; r < REQ_NUM; r++) begin : g_chk
    a_num_legal : assert property (@(posedge clk) disable iff (!rst_n)
      req_valid[r] |-> (req_num[r] != '0 && req_num[r] <= CNT_W'(M)));
    a_valid_hold : assert property (@(posedge clk) disable iff (!rst_n || clear)
      (req_valid[r] && !req_ready[r]) |=> req_valid[r]);
  end
`endif

endmodule

// File: tb/tb_multi_fifo_push_arb.sv
// Directed bench for multi_fifo_push_arb (M=4, REQ_NUM=4, STARVE_LIMIT=8).
// Lock scenarios are exercised when MULTI_FIFO_PUSH_ARB_STARVE_EN is defined;
// otherwise the same stimulus must leave the arbiter in plain round-robin.
module tb_multi_fifo_push_arb;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear;
  logic [3:0]           req_valid;
  logic [3:0][2:0]      req_num;
  logic [3:0][3:0][7:0] req_data;
  logic [3:0]           req_ready;
  logic [3:0]           fifo_almost_full;
  logic [3:0]           fifo_push;
  logic [3:0][7:0]      fifo_datain;
  logic                 lock_active;
  logic [1:0]           rr_ptr;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  multi_fifo_push_arb #(
    .T            (logic [7:0]),
    .M            (4),
    .REQ_NUM      (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .req_valid        (req_valid),
    .req_num          (req_num),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_almost_full (fifo_almost_full),
    .fifo_push        (fifo_push),
    .fifo_datain      (fifo_datain),
    .lock_active      (lock_active),
    .rr_ptr           (rr_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v, input int n0, input int n1,
                         input int n2, input int n3);
    req_valid  = v;
    req_num[0] = 3'(n0);
    req_num[1] = 3'(n1);
    req_num[2] = 3'(n2);
    req_num[3] = 3'(n3);
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] rdy,
                          input logic [3:0] psh, input logic [31:0] dat);
    chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, "_push"}, 32'(fifo_push), 32'(psh));
    chk({tag, "_data"}, fifo_datain, dat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b1;
    clear            = 1'b0;
    fifo_almost_full = 4'b0000;
    set_req(4'b0000, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        req_data[r][k] = 8'((r + 1) * 16 + k);
      end
    end
    #1 rst_n = 1'b0;
    #2;
    chk_outs("in_reset", 4'b0000, 4'b0000, 32'h0);
    chk("in_reset_rr", 32'(rr_ptr), 32'd0);
    chk("in_reset_lock", 32'(lock_active), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_outs("post_reset", 4'b0000, 4'b0000, 32'h0);
    chk("post_reset_rr", 32'(rr_ptr), 32'd0);
    chk("post_reset_lock", 32'(lock_active), 32'd0);

    // two requesters fill all four lanes, third does not fit
    set_req(4'b0111, 2, 2, 1, 0);
    #1 chk_outs("fill4", 4'b0011, 4'b1111, 32'h2120_1110);
    tick();
    chk("fill4_rr", 32'(rr_ptr), 32'd2);

    set_req(4'b0000, 0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_rr", 32'(rr_ptr), 32'd0);

    // free=1: req0 (3 entries) skipped, req1 (1 entry) packed at lane 0
    fifo_almost_full = 4'b1110;
    set_req(4'b0011, 3, 1, 0, 0);
    #1 chk_outs("skip_fit", 4'b0010, 4'b0001, 32'h0000_0020);
    tick();
    chk("skip_fit_rr", 32'(rr_ptr), 32'd2);

    // FIFO full: nothing moves
    fifo_almost_full = 4'b1111;
    set_req(4'b1111, 1, 1, 1, 1);
    #1 chk_outs("full", 4'b0000, 4'b0000, 32'h0);
    tick();
    chk("full_rr", 32'(rr_ptr), 32'd2);

    set_req(4'b0000, 0, 0, 0, 0);
    fifo_almost_full = 4'b0000;
    tick();

    // scan wraps 2,3,0 and skips 1
    set_req(4'b1111, 1, 1, 2, 1);
    #1 chk_outs("wrap", 4'b1101, 4'b1111, 32'h1040_3130);
    tick();
    chk("wrap_rr", 32'(rr_ptr), 32'd1);

    // free=2 from rr=1: 1 skip, 2 granted, 3 and 0 skip
    fifo_almost_full = 4'b1100;
    set_req(4'b1111, 2, 3, 1, 2);
    #1 chk_outs("free2", 4'b0100, 4'b0001, 32'h0000_0030);
    tick();
    chk("free2_rr", 32'(rr_ptr), 32'd3);

    set_req(4'b0000, 0, 0, 0, 0);
    fifo_almost_full = 4'b0000;
    tick();

    // req0 needs 4 with free=3 while req1 keeps winning
    fifo_almost_full = 4'b0001;
    set_req(4'b0011, 4, 1, 0, 0);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("starve%0d_ready", i), 32'(req_ready), 32'b0010);
      chk($sformatf("starve%0d_lock", i), 32'(lock_active), 32'd0);
      tick();
    end
`ifdef MULTI_FIFO_PUSH_ARB_STARVE_EN
    chk("lock_on", 32'(lock_active), 32'd1);
    chk_outs("lock_wait", 4'b0000, 4'b0000, 32'h0);
`else
    chk("nolock_on", 32'(lock_active), 32'd0);
    chk_outs("nolock_rr", 4'b0010, 4'b0001, 32'h0000_0020);
`endif
    chk("starve_rr", 32'(rr_ptr), 32'd2);
    tick();
    fifo_almost_full = 4'b0000;
    #1 chk_outs("starve_grant", 4'b0001, 4'b1111, 32'h1312_1110);
    tick();
    chk("starve_exit_lock", 32'(lock_active), 32'd0);
    chk("starve_exit_rr", 32'(rr_ptr), 32'd1);

    set_req(4'b0000, 0, 0, 0, 0);
    tick();

`ifdef MULTI_FIFO_PUSH_ARB_STARVE_EN
    // lock entered with rr_ptr=3, then cleared
    fifo_almost_full = 4'b0001;
    set_req(4'b0101, 4, 0, 1, 0);
    repeat (8) tick();
    chk("lock2_on", 32'(lock_active), 32'd1);
    chk("lock2_rr", 32'(rr_ptr), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("lock2_clear_lock", 32'(lock_active), 32'd0);
    chk("lock2_clear_rr", 32'(rr_ptr), 32'd0);
    repeat (7) tick();
    chk("cnt_restart_lock", 32'(lock_active), 32'd0);
    tick();
    chk("relock_on", 32'(lock_active), 32'd1);
    chk("relock_rr", 32'(rr_ptr), 32'd3);
`else
    set_req(4'b0100, 0, 0, 1, 0);
    tick();
    chk("rr3", 32'(rr_ptr), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear2_rr", 32'(rr_ptr), 32'd0);
    chk("clear2_lock", 32'(lock_active), 32'd0);
    tick();
    chk("rr3_again", 32'(rr_ptr), 32'd3);
`endif

    // asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_lock", 32'(lock_active), 32'd0);
    chk("async_rst_rr", 32'(rr_ptr), 32'd0);
    set_req(4'b0000, 0, 0, 0, 0);
    fifo_almost_full = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_outs("idle_after", 4'b0000, 4'b0000, 32'h0);
    chk("idle_after_rr", 32'(rr_ptr), 32'd0);
    chk("idle_after_lock", 32'(lock_active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
